// File: rtl/seq_mul16.sv
// seq_mul16: sequential 16x16 shift-and-add multiplier over a 32-bit ripple-carry adder
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [32:0] c;
  assign c[0] = c_in;
  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate
  assign c_out = c[32];
endmodule

module seq_mul16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] mcand, acc, sum;
  logic [WIDTH-1:0]   mplier;
  logic [4:0]         cnt;
  logic               load, last, c_out_unused;
  adder32 u_add (
    .a(acc),
    .b(mplier[0] ? mcand : '0),
    .c_in(1'b0),
    .sum(sum),
    .c_out(c_out_unused)
  );
  assign load = start && state != RUN;
  assign last = state == RUN && cnt == 5'd15;
  always_comb begin
    state_nx = load ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
        if (last) product <= sum;
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule
